instruction_sequencer: RTL
==========================

INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16, meaning memory wait-cycle limit before abort; 0 disables the timeout.
REQ-002 SHALL have parameter FLAG_N, default 4, meaning the width of i_flag_cond (bit FLAG_N-1 = C, then S, V, Z).
REQ-003 SHALL have port i_clk  in  1  single clock, with all state updating on the rising edge.
REQ-004 SHALL have port i_rst_n  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports i_ir1, i_ir2  in  16 each  first and second instruction words.
REQ-006 SHALL have port i_flag_cond  in  FLAG_N  condition flags.
REQ-007 SHALL have port i_mem_ack  in  1  memory access complete this cycle.
REQ-008 SHALL have port i_irq  in  1  level interrupt request; it exists only with IRQ_SEQ_EN.
REQ-009 SHALL have port o_state  out  inst_state_e  current state.
REQ-010 SHALL have port o_err  out  1  one-cycle pulse on an illegal state or a timeout.
REQ-011 SHALL have ports o_alu_op  out  alu_op_e; o_s1_addr, o_s2_addr, o_dest_addr, o_addr_reg  out  reg_id_e.
REQ-012 SHALL have ports o_mem_rd, o_mem_wr, o_reg_w_en, o_flag_w_en  out  1 each; o_stall  out  1  memory wait in progress.
REQ-013 SHALL have port o_irq_ack  out  1  one-cycle pulse on vector fetch completion; it exists only with IRQ_SEQ_EN.

Function
REQ-014 SHALL implement states IF1, D1, IF2, D2, IF3, D3, PUSH1, PUSH2, POP1, POP2, EXE, EXEA, RD and WR, plus INT1, INT2 and INT3 with IRQ_SEQ_EN.
REQ-015 SHALL decode instruction type as follows:
- op: i_ir1[15:14]=00
- load: i_ir1[15:12]=1000; store: 1001; call: 1011; pop: 1100; push: 1101
- 16-bit immediate: i_ir2[15:12] or i_ir2[11:8] equals R_IR3
REQ-016 SHALL make these transitions:
- IF1->D1
- D1->PUSH1 (push), POP1 (pop), else IF2
- IF2->D2
- D2->IF3 (imm16), PUSH1 (call), EXEA (load/store), else EXE
- IF3->D3
- D3 follows D2 without the imm16 branch
- PUSH1->PUSH2->EXE (call) or IF1
- POP1->POP2->IF1
- EXEA->RD (load) or WR (store)
- EXE, RD, WR->IF1
REQ-017 SHALL treat IF1, IF2, IF3, PUSH2, POP1, RD, WR, INT2 and INT3 as memory states, each holding until i_mem_ack=1 and advancing in the ack cycle.
REQ-018 SHALL assert o_stall when in a memory state with i_mem_ack=0.
REQ-019 SHALL drive the bus per state as follows:
- fetch states: MEM->IRn, address IP
- D states: IP inc
- PUSH1: SP dec
- PUSH2: ra1->MEM at SP
- POP1: MEM->ra1 at SP
- POP2: SP inc
- EXE: alu_op ra2,ra3->ra1
- EXEA: ->R_ADDR
- RD/WR: via R_ADDR
- unlisted signals default to ALU_MOV/R_ZR
REQ-020 SHALL set o_mem_rd=1 whenever s1 or s2 is R_MEM, and set the internal mem_wr when dest is R_MEM.
REQ-021 SHALL compute write-back enable wb as follows:
- in EXE, EXEA, RD, WR, PUSH1, PUSH2, POP1 and POP2: wb = selected flag XOR i_ir1[4], with type from i_ir1[7:5] and type NOP giving 0
- in all other states: wb = 1
REQ-022 SHALL drive o_reg_w_en=wb&adv, o_mem_wr=wb&mem_wr&adv and o_flag_w_en=wb&(state==EXE), where adv=1 outside memory states and adv=i_mem_ack inside them.
REQ-023 SHALL count consecutive stalled cycles and, if the count reaches TIMEOUT_CYC (when nonzero), pulse o_err, suppress all writes that cycle, go to IF1 and clear the counter.
REQ-024 SHALL clear the wait counter whenever the state changes.
REQ-025 SHALL, on an illegal state encoding, pulse o_err and go to IF1 next cycle.
REQ-026 SHALL give i_mem_ack priority over the timeout when both coincide in the same cycle.

Reset
REQ-027 SHALL set state=IF1, wait counter=0 and o_err=0 when i_rst_n is low, and drive the outputs to their IF1 values during reset.
REQ-028 SHALL, on reset asserted mid-access, abandon the access immediately and restart the first post-reset cycle in IF1.

Configuration
REQ-029 SHALL, with macro INSTRUCTION_SEQUENCER_IRQ_SEQ_EN defined, redirect any transition to IF1 while i_irq=1 to INT1 instead.
REQ-030 SHALL, with that macro defined, run the interrupt sequence:
- INT1: SP dec
- INT2: IP->MEM at SP
- INT3: MEM->IP at address R_ZR, i.e. vector 0x0000
- then IF1, pulsing o_irq_ack in the INT3 ack cycle
REQ-031 SHALL check i_irq only at instruction boundaries; a timeout abort also counts as a boundary.
REQ-032 SHALL, without the macro, have no INT states, no i_irq and no o_irq_ack, with behaviour as in the rest of this document.

Structure
REQ-033 SHALL add INT1, INT2 and INT3 to inst_state_e in common_pkg; alu_op_e, reg_id_e and flag_type_e stay in common_pkg.
REQ-034 SHALL place the flag-condition evaluation (flag type, invert and flags to wb bit) in sub-module cond_eval.

Verification
REQ-035 SHALL cover: ADD with no flag condition, i_mem_ack held at 1 -> IF1,D1,IF2,D2,EXE,IF1 with o_reg_w_en=1 and o_flag_w_en=1 in EXE.
REQ-036 SHALL cover: load with i_mem_ack=0 for 3 cycles in RD -> 3 stall cycles, o_reg_w_en=0, then write in the ack cycle.
REQ-037 SHALL cover: TIMEOUT_CYC=4 with no ack in WR -> o_err pulse on the 4th stalled cycle, o_mem_wr=0, next state IF1.
REQ-038 SHALL cover: EXE with Z condition (i_ir1[7:4]=0110), Z=0 -> o_reg_w_en=0 and o_flag_w_en=0; with i_ir1[4]=1 -> both 1.
REQ-039 SHALL cover: macro defined, i_irq=1 during push -> PUSH2 then INT1, INT2 (IP written), INT3, o_irq_ack pulse, then IF1.
REQ-040 SHALL cover: i_rst_n low during IF2 stall -> o_state=IF1 immediately and counter=0.

Source files
------------

// File: rtl/common_pkg.sv
// Shared types for the instruction sequencer: states, ALU ops, register ids and flag conditions.
// INT1..INT3 exist only when INSTRUCTION_SEQUENCER_IRQ_SEQ_EN is defined.
package common_pkg;

  typedef enum logic [4:0] {
    IF1   = 5'd0,
    D1    = 5'd1,
    IF2   = 5'd2,
    D2    = 5'd3,
    IF3   = 5'd4,
    D3    = 5'd5,
    PUSH1 = 5'd6,
    PUSH2 = 5'd7,
    POP1  = 5'd8,
    POP2  = 5'd9,
    EXE   = 5'd10,
    EXEA  = 5'd11,
    RD    = 5'd12,
    WR    = 5'd13
`ifdef INSTRUCTION_SEQUENCER_IRQ_SEQ_EN
    ,
    INT1  = 5'd14,
    INT2  = 5'd15,
    INT3  = 5'd16
`endif
  } inst_state_e;

  typedef enum logic [3:0] {
    ALU_MOV = 4'd0,
    ALU_ADD = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SHL = 4'd6,
    ALU_SHR = 4'd7,
    ALU_INC = 4'd8,
    ALU_DEC = 4'd9,
    ALU_ADC = 4'd10,
    ALU_SBC = 4'd11,
    ALU_NOT = 4'd12,
    ALU_CMP = 4'd13,
    ALU_ROL = 4'd14,
    ALU_ROR = 4'd15
  } alu_op_e;

  typedef enum logic [3:0] {
    R_ZR   = 4'd0,
    R_R1   = 4'd1,
    R_R2   = 4'd2,
    R_R3   = 4'd3,
    R_R4   = 4'd4,
    R_R5   = 4'd5,
    R_R6   = 4'd6,
    R_R7   = 4'd7,
    R_IP   = 4'd8,
    R_SP   = 4'd9,
    R_ADDR = 4'd10,
    R_IR1  = 4'd11,
    R_IR2  = 4'd12,
    R_IR3  = 4'd13,
    R_MEM  = 4'd14,
    R_FLG  = 4'd15
  } reg_id_e;

  // FT_NOP selects a constant 0, so "always" is encoded as NOP with invert set.
  typedef enum logic [2:0] {
    FT_NOP = 3'd0,
    FT_C   = 3'd1,
    FT_V   = 3'd2,
    FT_Z   = 3'd3,
    FT_S   = 3'd4,
    FT_ZC  = 3'd5,
    FT_LT  = 3'd6,
    FT_ALW = 3'd7
  } flag_type_e;

  function automatic logic is_mem_state(input inst_state_e s);
    case (s)
      IF1, IF2, IF3, PUSH2, POP1, RD, WR: return 1'b1;
`ifdef INSTRUCTION_SEQUENCER_IRQ_SEQ_EN
      INT2, INT3: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Flag-condition evaluation: selects one flag (or flag combination) by type and applies the invert bit.
module cond_eval
  import common_pkg::*;
#(
  parameter int FLAG_N = 4
) (
  input  flag_type_e        ftype,
  input  logic              invert,
  input  logic [FLAG_N-1:0] flags,
  output logic              wb
);

  logic c, s, v, z;
  logic sel;

  // Flag order from the top bit down: C, S, V, Z.
  assign c = flags[FLAG_N-1];
  assign s = flags[FLAG_N-2];
  assign v = flags[FLAG_N-3];
  assign z = flags[FLAG_N-4];

  always_comb begin
    sel = 1'b0;
    case (ftype)
      FT_NOP:  sel = 1'b0;
      FT_C:    sel = c;
      FT_V:    sel = v;
      FT_Z:    sel = z;
      FT_S:    sel = s;
      FT_ZC:   sel = z | c;
      FT_LT:   sel = s ^ v;
      FT_ALW:  sel = 1'b1;
      default: sel = 1'b0;
    endcase
    wb = sel ^ invert;
  end

endmodule

// File: rtl/instruction_sequencer.sv
// Microcode-style instruction sequencer: fetch/decode/execute FSM with memory wait timeout.
// Define INSTRUCTION_SEQUENCER_IRQ_SEQ_EN to add the interrupt entry sequence (INT1..INT3).
module instruction_sequencer
  import common_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int FLAG_N      = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [15:0]       i_ir1,
  input  logic [15:0]       i_ir2,
  input  logic [FLAG_N-1:0] i_flag_cond,
  input  logic              i_mem_ack,
`ifdef INSTRUCTION_SEQUENCER_IRQ_SEQ_EN
  input  logic              i_irq,
`endif
  output inst_state_e       o_state,
  output logic              o_err,
  output alu_op_e           o_alu_op,
  output reg_id_e           o_s1_addr,
  output reg_id_e           o_s2_addr,
  output reg_id_e           o_dest_addr,
  output reg_id_e           o_addr_reg,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic              o_reg_w_en,
  output logic              o_flag_w_en,
  output logic              o_stall
`ifdef INSTRUCTION_SEQUENCER_IRQ_SEQ_EN
  ,
  output logic              o_irq_ack
`endif
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC > 0) ? CNT_W'(TIMEOUT_CYC - 1) : '0;

  inst_state_e      state, nxt, target;
  logic [CNT_W-1:0] wait_cnt;
  logic             mem_state, stall, adv, timeout, illegal;
  logic             is_load, is_store, is_call, is_pop, is_push, imm16;
  reg_id_e          ra1, ra2, ra3;
  logic             cond_st, cond_wb, wb, mem_wr_int;
  logic             unused_ir2;

  assign is_load  = (i_ir1[15:12] == 4'b1000);
  assign is_store = (i_ir1[15:12] == 4'b1001);
  assign is_call  = (i_ir1[15:12] == 4'b1011);
  assign is_pop   = (i_ir1[15:12] == 4'b1100);
  assign is_push  = (i_ir1[15:12] == 4'b1101);
  assign imm16    = (i_ir2[15:12] == R_IR3) || (i_ir2[11:8] == R_IR3);
  assign ra1      = reg_id_e'(i_ir1[11:8]);
  assign ra2      = reg_id_e'(i_ir2[15:12]);
  assign ra3      = reg_id_e'(i_ir2[11:8]);
  assign unused_ir2 = ^i_ir2[7:0];

  assign mem_state = is_mem_state(state);
  assign stall     = mem_state & ~i_mem_ack;
  assign adv       = ~mem_state | i_mem_ack;
  // Ack wins over the timeout automatically: stall is only true without ack.
  assign timeout   = (TIMEOUT_CYC != 0) && stall && (wait_cnt == CNT_LAST);

  always_comb begin
    target  = IF1;
    illegal = 1'b0;
    case (state)
      IF1:   target = D1;
      D1:    target = is_push ? PUSH1 : (is_pop ? POP1 : IF2);
      IF2:   target = D2;
      D2:    target = imm16 ? IF3 : (is_call ? PUSH1 : ((is_load || is_store) ? EXEA : EXE));
      IF3:   target = D3;
      D3:    target = is_call ? PUSH1 : ((is_load || is_store) ? EXEA : EXE);
      PUSH1: target = PUSH2;
      PUSH2: target = is_call ? EXE : IF1;
      POP1:  target = POP2;
      POP2:  target = IF1;
      EXE:   target = IF1;
      EXEA:  target = is_load ? RD : WR;
      RD:    target = IF1;
      WR:    target = IF1;
`ifdef INSTRUCTION_SEQUENCER_IRQ_SEQ_EN
      INT1:  target = INT2;
      INT2:  target = INT3;
      INT3:  target = IF1;
`endif
      default: begin
        target  = IF1;
        illegal = 1'b1;
      end
    endcase
    nxt = adv ? target : state;
    if (timeout) nxt = IF1;
`ifdef INSTRUCTION_SEQUENCER_IRQ_SEQ_EN
    // Interrupts are taken only at instruction boundaries, including a timeout abort.
    if (i_irq && (nxt == IF1) && ((state != IF1) || timeout)) nxt = INT1;
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IF1;
      wait_cnt <= '0;
    end else begin
      state <= nxt;
      if (timeout || (nxt != state)) wait_cnt <= '0;
      else if (stall)                wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    o_alu_op    = ALU_MOV;
    o_s1_addr   = R_ZR;
    o_s2_addr   = R_ZR;
    o_dest_addr = R_ZR;
    o_addr_reg  = R_ZR;
    cond_st     = 1'b0;
    case (state)
      IF1, IF2, IF3: begin
        o_s1_addr   = R_MEM;
        o_dest_addr = (state == IF1) ? R_IR1 : ((state == IF2) ? R_IR2 : R_IR3);
        o_addr_reg  = R_IP;
      end
      D1, D2, D3: begin
        o_alu_op    = ALU_INC;
        o_s1_addr   = R_IP;
        o_dest_addr = R_IP;
      end
      PUSH1: begin
        o_alu_op    = ALU_DEC;
        o_s1_addr   = R_SP;
        o_dest_addr = R_SP;
        cond_st     = 1'b1;
      end
      PUSH2: begin
        o_s1_addr   = ra1;
        o_dest_addr = R_MEM;
        o_addr_reg  = R_SP;
        cond_st     = 1'b1;
      end
      POP1: begin
        o_s1_addr   = R_MEM;
        o_dest_addr = ra1;
        o_addr_reg  = R_SP;
        cond_st     = 1'b1;
      end
      POP2: begin
        o_alu_op    = ALU_INC;
        o_s1_addr   = R_SP;
        o_dest_addr = R_SP;
        cond_st     = 1'b1;
      end
      EXE: begin
        o_alu_op    = alu_op_e'(i_ir1[3:0]);
        o_s1_addr   = ra2;
        o_s2_addr   = ra3;
        o_dest_addr = ra1;
        cond_st     = 1'b1;
      end
      // Effective address is base register plus offset register.
      EXEA: begin
        o_alu_op    = ALU_ADD;
        o_s1_addr   = ra2;
        o_s2_addr   = ra3;
        o_dest_addr = R_ADDR;
        cond_st     = 1'b1;
      end
      RD: begin
        o_s1_addr   = R_MEM;
        o_dest_addr = ra1;
        o_addr_reg  = R_ADDR;
        cond_st     = 1'b1;
      end
      WR: begin
        o_s1_addr   = ra1;
        o_dest_addr = R_MEM;
        o_addr_reg  = R_ADDR;
        cond_st     = 1'b1;
      end
`ifdef INSTRUCTION_SEQUENCER_IRQ_SEQ_EN
      INT1: begin
        o_alu_op    = ALU_DEC;
        o_s1_addr   = R_SP;
        o_dest_addr = R_SP;
      end
      INT2: begin
        o_s1_addr   = R_IP;
        o_dest_addr = R_MEM;
        o_addr_reg  = R_SP;
      end
      INT3: begin
        o_s1_addr   = R_MEM;
        o_dest_addr = R_IP;
        o_addr_reg  = R_ZR;
      end
`endif
      default: ;
    endcase
  end

  cond_eval #(.FLAG_N(FLAG_N)) u_cond_eval (
    .ftype  (flag_type_e'(i_ir1[7:5])),
    .invert (i_ir1[4]),
    .flags  (i_flag_cond),
    .wb     (cond_wb)
  );

  assign wb          = cond_st ? cond_wb : 1'b1;
  assign mem_wr_int  = (o_dest_addr == R_MEM);
  assign o_state     = state;
  assign o_stall     = stall;
  assign o_mem_rd    = (o_s1_addr == R_MEM) || (o_s2_addr == R_MEM);
  assign o_reg_w_en  = wb & adv;
  assign o_mem_wr    = wb & mem_wr_int & adv;
  assign o_flag_w_en = wb & (state == EXE);
  assign o_err       = (illegal | timeout) & i_rst_n;
`ifdef INSTRUCTION_SEQUENCER_IRQ_SEQ_EN
  assign o_irq_ack   = (state == INT3) & i_mem_ack;
`endif

endmodule
